// File: rtl/gf_poly_reducer_if.sv
// Handshake and data bundle for gf_poly_reducer.
// The producer side drives the product/modulus and accepts the remainder;
// the reducer side uses the slave modport.
interface gf_poly_reducer_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic [2*DATA_WIDTH-1:0] prod_in;
  logic [DATA_WIDTH-1:0]   poly;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH-1:0]   rem_out;
  logic                    busy;

  modport master (
    output in_valid, prod_in, poly, out_ready,
    input  in_ready, out_valid, rem_out, busy
  );

  modport slave (
    input  in_valid, prod_in, poly, out_ready,
    output in_ready, out_valid, rem_out, busy
  );
endinterface

// File: rtl/gf_poly_reducer.sv
// Iterative GF(2^W) reduction of a 2W-bit carry-less product modulo
// x^W + poly, STEPS_PER_CYCLE bit positions per clock, valid/ready on both
// sides.
// Optional macro GF_REDUCE_EARLY_EXIT_EN: finish as soon as the upper half
// of the working register is already zero.
module gf_poly_reducer #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned STEPS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  gf_poly_reducer_if.slave bus
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned S  = STEPS_PER_CYCLE;
  localparam int unsigned RW = 2 * W;
  localparam int unsigned IW = $clog2(RW);

  generate
    if (S == 0 || (W % S) != 0) begin : g_bad_steps
      $error("STEPS_PER_CYCLE must be nonzero and divide DATA_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    DONE
  } state_t;

  state_t          state;
  logic [RW-1:0]   r;
  logic [RW-1:0]   r_next;
  logic [W:0]      m;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   pos;
  logic            last_edge;
`ifdef GF_REDUCE_EARLY_EXIT_EN
  logic            upper_zero;

  assign upper_zero = ~|r[RW-1:W];
`endif

  // The final reducing edge is the one whose lowest processed position is W.
  assign last_edge = (idx == IW'(W + S - 1));

  // Chain S reduction steps from idx downward within one cycle.
  always_comb begin
    r_next = r;
    pos    = '0;
    for (int unsigned s = 0; s < S; s++) begin
      pos = idx - IW'(s);
      if (r_next[pos]) begin
        r_next = r_next ^ (RW'(m) << (pos - IW'(W)));
      end
    end
  end

  // Control FSM with registered handshake outputs and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.rem_out   <= '0;
      r             <= '0;
      m             <= '0;
      idx           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            r            <= bus.prod_in;
            m            <= {1'b1, bus.poly};
            idx          <= IW'(RW - 1);
            state        <= REDUCE;
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b1;
          end
        end
        REDUCE: begin
`ifdef GF_REDUCE_EARLY_EXIT_EN
          if (upper_zero) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.rem_out   <= r[W-1:0];
          end else
`endif
          begin
            r   <= r_next;
            idx <= idx - IW'(S);
            if (last_edge) begin
              state         <= DONE;
              bus.out_valid <= 1'b1;
              bus.rem_out   <= r_next[W-1:0];
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.in_ready  <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf_poly_reducer.sv
// Bench for gf_poly_reducer: four lanes (W=32/S=1, W=8/S=1,2,4) share one
// stimulus stream; a residue-based GF model tracks each lane every cycle.
module tb_gf_poly_reducer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] prod;
  logic [31:0] poly;

  always #5 clk = ~clk;

  logic        l_ir   [4];
  logic        l_ov   [4];
  logic        l_busy [4];
  logic [31:0] l_rem  [4];

  for (genvar g = 0; g < 4; g++) begin : lane
    localparam int unsigned W = (g == 0) ? 32 : 8;
    localparam int unsigned S = (g == 0) ? 1 : (1 << (g - 1));
    gf_poly_reducer_if #(.DATA_WIDTH(W)) b ();
    assign b.in_valid  = in_valid;
    assign b.prod_in   = prod[2*W-1:0];
    assign b.poly      = poly[W-1:0];
    assign b.out_ready = out_ready;
    gf_poly_reducer #(.DATA_WIDTH(W), .STEPS_PER_CYCLE(S)) dut (
      .clk(clk),
      .rst(rst),
      .bus(b)
    );
    assign l_ir[g]   = b.in_ready;
    assign l_ov[g]   = b.out_valid;
    assign l_busy[g] = b.busy;
    assign l_rem[g]  = 32'(b.rem_out);
  end

  int checks   = 0;
  int failures = 0;

  function automatic int unsigned lw(int unsigned l);
    return (l == 0) ? 32 : 8;
  endfunction

  function automatic int unsigned ls(int unsigned l);
    return (l == 0) ? 1 : (1 << (l - 1));
  endfunction

  task automatic chk(input string nm, input int lane_n, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s lane=%0d got=%0h exp=%0h t=%0t", nm, lane_n, got, exp, $time);
    end
  endtask

  // Remainder as XOR of (x^i mod P) over the set bits of p.
  function automatic logic [31:0] gf_ref(input logic [63:0] p, input logic [31:0] q,
                                         input int unsigned w);
    logic [31:0] mask;
    logic [31:0] xi;
    logic [31:0] res;
    logic        top;
    mask = 32'hFFFF_FFFF >> (32 - w);
    xi   = 32'd1;
    res  = '0;
    for (int unsigned i = 0; i < 2 * w; i++) begin
      if (p[i]) res = res ^ xi;
      top = xi[w-1];
      xi  = (xi << 1) & mask;
      if (top) xi = xi ^ (q & mask);
    end
    return res;
  endfunction

  // Edges from accept to out_valid.
  function automatic int lat_of(input logic [63:0] p, input logic [31:0] q,
                                input int unsigned w, input int unsigned s);
`ifdef GF_REDUCE_EARLY_EXIT_EN
    logic [63:0] rr;
    logic [63:0] md;
    int unsigned j;
    rr = p;
    md = (64'd1 << w) | 64'(q);
    for (int unsigned k = 0; k < w / s; k++) begin
      if ((rr >> w) == 64'd0) return int'(k + 1);
      for (int unsigned t = 0; t < s; t++) begin
        j = 2 * w - 1 - k * s - t;
        if (rr[j]) rr = rr ^ (md << (j - w));
      end
    end
    return int'(w / s);
`else
    return int'(w / s);
`endif
  endfunction

  // Per-lane behavioural model: 0 idle, 1 reducing, 2 result held.
  int          ph [4];
  int          ed [4];
  int          lt [4];
  logic [31:0] ex [4];
  logic [31:0] rm [4];
  logic        acc[4];
  logic        tk [4];
  logic [63:0] sp [4];
  logic [31:0] sq [4];
  logic        rs;
  logic        armed = 1'b0;

  // Single compare process: advance model for the edge just passed, compare, sample.
  always @(negedge clk) begin
    if (armed) begin
      for (int unsigned l = 0; l < 4; l++) begin
        if (rs) begin
          ph[l] = 0;
          rm[l] = '0;
        end else begin
          case (ph[l])
            0: if (acc[l]) begin
              ph[l] = 1;
              ed[l] = 0;
              ex[l] = gf_ref(sp[l], sq[l], lw(l));
              lt[l] = lat_of(sp[l], sq[l], lw(l), ls(l));
            end
            1: begin
              ed[l]++;
              if (ed[l] == lt[l]) begin
                ph[l] = 2;
                rm[l] = ex[l];
              end
            end
            default: if (tk[l]) ph[l] = 0;
          endcase
        end
        chk("in_ready", l, 64'(l_ir[l]), 64'(ph[l] == 0));
        chk("out_valid", l, 64'(l_ov[l]), 64'(ph[l] == 2));
        chk("busy", l, 64'(l_busy[l]), 64'(ph[l] != 0));
        chk("rem_out", l, 64'(l_rem[l]), 64'(rm[l]));
      end
    end
    for (int unsigned l = 0; l < 4; l++) begin
      acc[l] = in_valid && (ph[l] == 0);
      tk[l]  = out_ready && (ph[l] == 2);
      sp[l]  = (lw(l) == 32) ? prod : (prod & ((64'd1 << (2 * lw(l))) - 64'd1));
      sq[l]  = poly & (32'hFFFF_FFFF >> (32 - lw(l)));
    end
    rs = rst;
    if (rst) armed = 1'b1;
  end

  logic [31:0] res_rem[4];
  int          res_lat[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit all_idle();
    for (int unsigned l = 0; l < 4; l++) if (!l_ir[l]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle();
    for (int c = 0; c < 200; c++) begin
      if (all_idle()) return;
      tick();
    end
    chk("idle_timeout", 0, 64'd0, 64'd1);
  endtask

  task automatic run_op(input logic [63:0] p, input logic [31:0] q, input bit zero_poly);
    bit got[4];
    bit done;
    wait_idle();
    prod      = p;
    poly      = q;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    if (zero_poly) poly = '0;
    for (int unsigned l = 0; l < 4; l++) got[l] = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      done = 1'b1;
      for (int unsigned l = 0; l < 4; l++) begin
        if (!got[l] && l_ov[l]) begin
          got[l]     = 1'b1;
          res_rem[l] = l_rem[l];
          res_lat[l] = c;
        end
        if (!got[l]) done = 1'b0;
      end
      if (!done) tick();
    end
    if (!done) chk("result_timeout", 0, 64'd0, 64'd1);
  endtask

  logic [63:0] p1, p2, pr;
  logic [31:0] q1, q2, qr;
  bit          seen;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    prod      = '0;
    poly      = '0;
    repeat (3) tick();
    rst = 1'b0;

    chk("ref_pin_78", 0, 64'(gf_ref(64'h78, 32'h8D, 32)), 64'h78);
    chk("ref_pin_c1", 1, 64'(gf_ref(64'h2B79, 32'h1B, 8)), 64'hC1);
    chk("ref_pin_x32", 0, 64'(gf_ref(64'h1_0000_0000, 32'h8D, 32)), 64'h8D);

    run_op(64'h78, 32'h8D, 1'b0);
    chk("clmul_12x10", 0, 64'(res_rem[0]), 64'h78);
`ifdef GF_REDUCE_EARLY_EXIT_EN
    chk("lat_12x10", 0, 64'(res_lat[0]), 64'd1);
`else
    chk("lat_12x10", 0, 64'(res_lat[0]), 64'd32);
`endif

    run_op(64'h2B79, 32'h1B, 1'b0);
    for (int unsigned l = 1; l < 4; l++) chk("aes_57x83", int'(l), 64'(res_rem[l]), 64'hC1);
`ifndef GF_REDUCE_EARLY_EXIT_EN
    chk("lat_w8_s1", 1, 64'(res_lat[1]), 64'd8);
    chk("lat_w8_s2", 2, 64'(res_lat[2]), 64'd4);
    chk("lat_w8_s4", 3, 64'(res_lat[3]), 64'd2);
`endif

    run_op(64'h1_0000_0000, 32'h8D, 1'b1);
    chk("x32_poly_late_change", 0, 64'(res_rem[0]), 64'h8D);

    // Backpressure with a second operand waiting on in_valid.
    p1 = 64'h0123_4567_89AB_CDEF;
    q1 = 32'h0400_0007;
    p2 = 64'h7FED_CBA9_8765_4321;
    q2 = 32'h0000_00C5;
    wait_idle();
    prod      = p1;
    poly      = q1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      if (l_ov[0]) seen = 1'b1;
      else tick();
    end
    chk("bp_reach_done", 0, 64'(seen), 64'd1);
    repeat (5) begin
      tick();
      chk("bp_rem_stable", 0, 64'(l_rem[0]), 64'(gf_ref(p1, q1, 32)));
      chk("bp_in_ready", 0, 64'(l_ir[0]), 64'd0);
    end
    prod      = p2;
    poly      = q2;
    out_ready = 1'b1;
    tick();
    chk("bp_back_idle", 0, 64'({l_ir[0], l_ov[0]}), 64'b10);
    tick();
    in_valid = 1'b0;
    chk("bp_second_accept", 0, 64'({l_ir[0], l_busy[0]}), 64'b01);
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      if (l_ov[0]) seen = 1'b1;
      else tick();
    end
    chk("bp_second_result", 0, 64'(l_rem[0]), 64'(gf_ref(p2, q2, 32)));

    // Reset in the middle of a reduction.
    wait_idle();
    prod     = 64'h8000_1234_5678_9ABC;
    poly     = 32'h0000_008D;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_in_ready", 0, 64'(l_ir[0]), 64'd1);
    chk("rst_out_valid", 0, 64'(l_ov[0]), 64'd0);
    chk("rst_busy", 0, 64'(l_busy[0]), 64'd0);
    chk("rst_rem", 0, 64'(l_rem[0]), 64'd0);
    run_op(64'hFEDC_BA98_7654_3210, 32'h0040_0003, 1'b0);
    chk("post_rst_op", 0, 64'(res_rem[0]), 64'(gf_ref(64'hFEDC_BA98_7654_3210, 32'h0040_0003, 32)));

    // poly = 0 leaves the low half untouched.
    for (int i = 0; i < 20; i++) begin
      pr = {$urandom(), $urandom()};
      run_op(pr, 32'd0, 1'b0);
      chk("poly_zero", 0, 64'(res_rem[0]), 64'(pr[31:0]));
    end

    // Random products and moduli; per-cycle model comparison does the checking.
    for (int i = 0; i < 1000; i++) begin
      pr = {$urandom(), $urandom()};
      qr = $urandom();
      run_op(pr, qr, ($urandom_range(0, 3) == 0));
    end

    wait_idle();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
